// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit: funct3 branch encodings,
// boolean constants and the weakly-not-taken counter reset value.
package branch_predict_unit_pkg;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // 2^(ctr_bits-1)-1: the largest value whose MSB still predicts not-taken
    function automatic logic [3:0] weak_not_taken(input int unsigned ctr_bits);
        return (4'b0001 << (ctr_bits - 1)) - 4'b0001;
    endfunction

endpackage

// File: rtl/branch_predict_unit_cmp.sv
// branch_cmp: combinational RV32 conditional-branch comparator producing the
// resolved direction plus a flag for the unused funct3 encodings 010/011.
module branch_cmp
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            illegal
);

    // Condition decode; illegal encodings never report taken
    always_comb begin
        taken   = FALSE;
        illegal = FALSE;
        case (funct3)
            BR_EQ:   taken = (rs1 == rs2);
            BR_NE:   taken = (rs1 != rs2);
            BR_LT:   taken = ($signed(rs1) <  $signed(rs2));
            BR_GE:   taken = ($signed(rs1) >= $signed(rs2));
            BR_LTU:  taken = (rs1 <  rs2);
            BR_GEU:  taken = (rs1 >= rs2);
            default: illegal = TRUE;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution plus BHT direction predictor (flop-based counter table).
// Optional gshare indexing is enabled by defining GSHARE_EN.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int GHR_BITS    = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                f_valid,
    input  logic [XLEN-1:0]     f_pc,
    output logic                f_pred_taken,
    output logic [GHR_BITS-1:0] f_ghr,
    input  logic                ex_valid,
    input  logic                ex_is_branch,
    input  logic [2:0]          ex_funct3,
    input  logic [XLEN-1:0]     ex_pc,
    input  logic [XLEN-1:0]     ex_rs1,
    input  logic [XLEN-1:0]     ex_rs2,
    input  logic                ex_pred_taken,
    input  logic [GHR_BITS-1:0] ex_ghr,
    output logic                ex_branch_taken,
    output logic                ex_mispredict
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_RESET = CTR_BITS'(weak_not_taken(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX   = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_MIN   = {CTR_BITS{1'b0}};

    logic [CTR_BITS-1:0] ctr_r [BHT_ENTRIES];
    logic [IDX_W-1:0]    f_idx_s;
    logic [IDX_W-1:0]    t_idx_s;
    logic                cmp_taken_s;
    logic                cmp_illegal_s;
    logic                resolving_s;
    logic                train_s;
    logic                unused_pc_s;

    branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
        .rs1     (ex_rs1),
        .rs2     (ex_rs2),
        .funct3  (ex_funct3),
        .taken   (cmp_taken_s),
        .illegal (cmp_illegal_s)
    );

    assign resolving_s     = ex_valid & ex_is_branch;
    assign train_s         = resolving_s & ~cmp_illegal_s;
    assign ex_branch_taken = train_s & cmp_taken_s;
    assign ex_mispredict   = train_s & (ex_branch_taken != ex_pred_taken);

    // Only the word-aligned index bits take part in lookup and training
    assign unused_pc_s = ^{f_pc[1:0], f_pc[XLEN-1:IDX_W+2], ex_pc[1:0], ex_pc[XLEN-1:IDX_W+2]};

`ifdef GSHARE_EN
    logic [GHR_BITS-1:0] ghr_r;

    assign f_idx_s = f_pc[IDX_W+1:2] ^ IDX_W'(ghr_r);
    assign t_idx_s = ex_pc[IDX_W+1:2] ^ IDX_W'(ex_ghr);
    assign f_ghr   = ghr_r;

    // Non-speculative history: shifts in resolved direction of legal branches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_r <= {GHR_BITS{1'b0}};
        end else if (train_s) begin
            ghr_r <= GHR_BITS'({ghr_r, ex_branch_taken});
        end
    end
`else
    logic unused_ghr_s;

    assign f_idx_s      = f_pc[IDX_W+1:2];
    assign t_idx_s      = ex_pc[IDX_W+1:2];
    assign f_ghr        = {GHR_BITS{1'b0}};
    assign unused_ghr_s = ^ex_ghr;
`endif

    // Lookup reads the registered table directly, so a same-cycle update is not bypassed
    assign f_pred_taken = f_valid & ctr_r[f_idx_s][CTR_BITS-1];

    // Saturating counter training at the edge after a legal resolving branch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr_r[i] <= CTR_RESET;
            end
        end else if (train_s) begin
            if (ex_branch_taken) begin
                if (ctr_r[t_idx_s] != CTR_MAX) begin
                    ctr_r[t_idx_s] <= ctr_r[t_idx_s] + CTR_BITS'(1);
                end
            end else if (ctr_r[t_idx_s] != CTR_MIN) begin
                ctr_r[t_idx_s] <= ctr_r[t_idx_s] - CTR_BITS'(1);
            end
        end
    end

endmodule
